// File: rtl/inst_sram_resp.sv
// Instruction SRAM response shim: accepts one fetch at a time, reads a 64-bit RAM word,
// and returns it as up to two 32-bit instructions a fixed LATENCY cycles after acceptance.
module inst_sram_resp #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        data_ok1,
    output logic        data_ok2,
    output logic [63:0] rdata,
    output logic        mem_en,
    output logic [28:0] mem_addr,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] buf_q, buf_d;
    logic        mem_en_q, mem_en_d;
    logic        cap_q, cap_d;

    assign addr_ok = req & ~flush & ((state_q == S_IDLE) | (state_q == S_RESP));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mem_en_d = addr_ok & (addr[1:0] == 2'b00);
        // RAM data arrives the cycle after mem_en; capture it then.
        cap_d    = mem_en_q;
        buf_d    = cap_q ? mem_rdata : buf_q;

        case (state_q)
            S_IDLE: if (addr_ok) state_d = S_WAIT;
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_RESP;
                end
            end
            S_RESP:  state_d = addr_ok ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (addr_ok) begin
            addr_d = addr;
            cnt_d  = CNT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            buf_q    <= 64'd0;
            mem_en_q <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            mem_en_q <= mem_en_d;
            cap_q    <= cap_d;
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_addr = addr_q[31:3];
    assign data_ok  = (state_q == S_RESP) & ~flush;

    // Word offset picks full, upper-half-only, or no instructions.
    always_comb begin
        rdata    = 64'd0;
        data_ok1 = 1'b0;
        data_ok2 = 1'b0;
        if (data_ok && addr_q[1:0] == 2'b00) begin
            data_ok1 = 1'b1;
            if (addr_q[2]) begin
                rdata = {32'd0, buf_q[63:32]};
            end else begin
                rdata    = buf_q;
                data_ok2 = 1'b1;
            end
        end
    end

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 Parameter LATENCY, default 3, cycles from request acceptance to data_ok; legal range 3..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req  input  1  CPU fetch request valid.
REQ-005 addr  input  32  fetch byte address (PC of first instruction).
REQ-006 flush  input  1  discard outstanding fetch and block acceptance this cycle.
REQ-007 addr_ok  output  1  request accepted this cycle.
REQ-008 data_ok  output  1  response valid this cycle (one-cycle pulse).
REQ-009 data_ok1  output  1  rdata[31:0] holds a valid instruction.
REQ-010 data_ok2  output  1  rdata[63:32] holds a valid instruction.
REQ-011 rdata  output  64  {inst2, inst1} fetch data.
REQ-012 mem_en  output  1  backing RAM read enable (one-cycle pulse).
REQ-013 mem_addr  output  29  backing RAM 64-bit word index, equals latched addr[31:3].
REQ-014 mem_rdata  input  64  backing RAM data, valid the cycle after mem_en.

Function
REQ-015 States SHALL be IDLE, WAIT and RESP, with a 4-bit down-counter and a latched address register.
REQ-016 addr_ok SHALL equal req & ~flush & (state==IDLE | state==RESP), combinationally.
REQ-017 On acceptance at cycle T: latch addr; load counter with LATENCY-1; next state WAIT.
REQ-018 mem_en SHALL be 1 at T+1 only, and only if latched addr[1:0]==0; mem_addr SHALL be stable from T+1 until the next acceptance.
REQ-019 mem_rdata SHALL be captured into the response buffer at the end of T+2.
REQ-020 Counter SHALL decrement each WAIT cycle; when counter reaches 1 in WAIT, next state SHALL be RESP, so RESP is at cycle T+LATENCY.
REQ-021 data_ok SHALL equal (state==RESP) & ~flush; rdata, data_ok1 and data_ok2 SHALL be 0 whenever data_ok is 0.
REQ-022 Aligned case, addr[2:0]==0: rdata = buffer; data_ok1=1, data_ok2=1.
REQ-023 Half case, addr[2]==1 and addr[1:0]==0: rdata[31:0] = buffer[63:32]; rdata[63:32]=0; data_ok1=1, data_ok2=0.
REQ-024 Misaligned case, addr[1:0]!=0: no mem_en; response still occurs at T+LATENCY with data_ok=1, data_ok1=0, data_ok2=0 and rdata=0.
REQ-025 In RESP, if addr_ok=1, the next request SHALL be accepted in the same cycle and the state SHALL go to WAIT; otherwise the state SHALL go to IDLE. Peak throughput is one fetch per LATENCY cycles.
REQ-026 flush=1 in WAIT or RESP SHALL force next state IDLE and suppress that response permanently; a mem_en already issued completes harmlessly and its data is ignored.
REQ-027 flush=1 together with req in IDLE or RESP: no acceptance (flush wins).
REQ-028 req while in WAIT SHALL be ignored (addr_ok=0); the requester SHALL hold req until addr_ok.

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, latched address 0 and response buffer 0, which makes data_ok, data_ok1, data_ok2, rdata, mem_en, mem_addr and addr_ok all 0 in the following cycle.
REQ-030 Reset asserted during WAIT or RESP SHALL drop the outstanding fetch; no data_ok SHALL follow reset deassertion until a new acceptance plus LATENCY cycles.

Verification
REQ-031 Aligned fetch, LATENCY=3: req at T with addr=0xBFC00000; RAM word 0x24020001_3C01BFC0 -> addr_ok@T, mem_en@T+1 with mem_addr=0x17F80000, data_ok@T+3 with rdata=0x24020001_3C01BFC0, data_ok1=1, data_ok2=1.
REQ-032 Half fetch: addr=0xBFC00004, same RAM word -> rdata=0x00000000_24020001, data_ok1=1, data_ok2=0.
REQ-033 Misaligned: addr=0xBFC00002 -> no mem_en; data_ok@T+3 with data_ok1=0, data_ok2=0, rdata=0.
REQ-034 Back-to-back, req held high, LATENCY=5: accept 0x00 then 0x08 -> acceptances at T and T+5, data_ok pulses at T+5 and T+10, no gap.
REQ-035 Flush: accept at T, flush=1 at T+2 -> no data_ok at T+3, state IDLE; new req at T+3 is accepted at T+3 and responds at T+6.
REQ-036 Reset mid-WAIT: accept at T, rst=1 at T+1 -> all outputs 0 from T+2, no data_ok ever produced for that fetch.
